// File: rtl/cam_frame_capture_pkg.sv
// Shared state encoding and default frame geometry for the camera capture front end.
package cam_frame_capture_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_VS,
        S_SKIP,
        S_CAPTURE,
        S_DONE
    } cap_state_t;

    localparam int DEF_H_ACTIVE    = 320;
    localparam int DEF_V_ACTIVE    = 240;
    localparam int DEF_ADDR_W      = 17;
    localparam int DEF_SKIP_FRAMES = 2;

endpackage

// File: rtl/cam_frame_capture_sync_edge.sv
// Camera input register stage with rise/fall detection on the registered vsync/href.
module cam_sync_edge (
    input  logic       pclk,
    input  logic       rst,
    input  logic       vsync,
    input  logic       href,
    input  logic [7:0] din,
    output logic       hr_q,
    output logic [7:0] din_q,
    output logic       vs_rise,
    output logic       vs_fall,
    output logic       hr_rise,
    output logic       hr_fall
);
    logic vs_q;
    logic vs_prev;
    logic hr_prev;

    always_ff @(posedge pclk) begin
        if (rst) begin
            vs_q    <= 1'b0;
            vs_prev <= 1'b0;
            hr_q    <= 1'b0;
            hr_prev <= 1'b0;
            din_q   <= '0;
        end else begin
            vs_q    <= vsync;
            vs_prev <= vs_q;
            hr_q    <= href;
            hr_prev <= hr_q;
            din_q   <= din;
        end
    end

    assign vs_rise = vs_q & ~vs_prev;
    assign vs_fall = ~vs_q & vs_prev;
    assign hr_rise = hr_q & ~hr_prev;
    assign hr_fall = ~hr_q & hr_prev;

endmodule

// File: rtl/cam_frame_capture.sv
// One-shot camera frame grabber: byte pairs -> RGB565 pixels with linear frame addresses.
module cam_frame_capture
    import cam_frame_capture_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int SKIP_FRAMES = DEF_SKIP_FRAMES
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              enable,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_din,
    output logic [ADDR_W-1:0] cam_addr,
    output logic [15:0]       cam_data,
    output logic              cam_we,
    output logic              busy,
    output logic              frame_done,
    output logic              short_frame
);
    localparam int CW  = $clog2(H_ACTIVE + 1);
    localparam int LW  = $clog2(V_ACTIVE + 1);
    localparam int SKW = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;

    localparam logic [CW-1:0]     H_N       = CW'(H_ACTIVE);
    localparam logic [LW-1:0]     V_N       = LW'(V_ACTIVE);
    localparam logic [LW-1:0]     V_LAST    = LW'(V_ACTIVE - 1);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE);
    localparam logic [SKW-1:0]    SKIP_N    = SKW'(SKIP_FRAMES);

    cap_state_t state_q, state_d;

    logic              hr_q;
    logic [7:0]        din_q;
    logic              vs_rise, vs_fall, hr_rise, hr_fall;

    logic [SKW-1:0]    skip_cnt;
    logic [CW-1:0]     col;
    logic [LW-1:0]     line;
    logic [LW-1:0]     line_after;
    logic [ADDR_W-1:0] line_base;
    logic [7:0]        hi_byte;
    logic              phase;
    logic              short_q;
    logic              line_end;
    logic              cap_active;
    logic              cap_enter;

    cam_sync_edge u_sync (
        .pclk    (pclk),
        .rst     (rst),
        .vsync   (cam_vsync),
        .href    (cam_href),
        .din     (cam_din),
        .hr_q    (hr_q),
        .din_q   (din_q),
        .vs_rise (vs_rise),
        .vs_fall (vs_fall),
        .hr_rise (hr_rise),
        .hr_fall (hr_fall)
    );

    always_ff @(posedge pclk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:    state_d = S_WAIT_VS;
                S_WAIT_VS: if (vs_fall) state_d = (skip_cnt < SKIP_N) ? S_SKIP : S_CAPTURE;
                S_SKIP:    if (vs_rise) state_d = S_WAIT_VS;
                S_CAPTURE: if (vs_rise) state_d = S_DONE;
                S_DONE:    state_d = S_DONE;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    assign busy        = (state_q == S_WAIT_VS) || (state_q == S_SKIP) || (state_q == S_CAPTURE);
    assign frame_done  = (state_q == S_DONE);
    assign short_frame = short_q && (state_q == S_DONE);

    assign cap_active = (state_q == S_CAPTURE) && enable;
    assign cap_enter  = (state_q != S_CAPTURE) && (state_d == S_CAPTURE);
    assign line_end   = hr_fall && (col != '0);
    // Line count as it will stand after this edge, so a coincident href fall counts its line.
    assign line_after = (line_end && (line < V_N)) ? line + 1'b1 : line;

    always_ff @(posedge pclk) begin
        if (rst) begin
            skip_cnt  <= '0;
            col       <= '0;
            line      <= '0;
            line_base <= '0;
            hi_byte   <= '0;
            phase     <= 1'b0;
            short_q   <= 1'b0;
            cam_we    <= 1'b0;
            cam_addr  <= '0;
            cam_data  <= '0;
        end else begin
            cam_we <= 1'b0;

            if (state_q == S_IDLE)
                skip_cnt <= '0;
            else if ((state_q == S_SKIP) && vs_rise && enable)
                skip_cnt <= skip_cnt + 1'b1;

            if (cap_enter) begin
                col       <= '0;
                line      <= '0;
                line_base <= '0;
                phase     <= 1'b0;
                short_q   <= 1'b0;
            end else if (cap_active) begin
                if (hr_fall) begin
                    phase <= 1'b0;
                    if (line_end) begin
                        col <= '0;
                        if (line < V_N)    line      <= line + 1'b1;
                        if (line < V_LAST) line_base <= line_base + LINE_STEP;
                        if (col < H_N)     short_q   <= 1'b1;
                    end
                end else if (hr_q && !vs_rise) begin
                    if (hr_rise || !phase) begin
                        hi_byte <= din_q;
                        phase   <= 1'b1;
                    end else begin
                        phase <= 1'b0;
                        // Column saturates at H_ACTIVE; pixels past the edge are dropped.
                        if (col < H_N) begin
                            col <= col + 1'b1;
                            if (line < V_N) begin
                                cam_we   <= 1'b1;
                                cam_data <= {hi_byte, din_q};
                                cam_addr <= line_base + ADDR_W'(col);
                            end
                        end
                    end
                end

                if (vs_rise) begin
                    phase <= 1'b0;
                    if (line_after < V_N) short_q <= 1'b1;
                end
            end
        end
    end

endmodule
